// File: rtl/addr_sequencer.sv
// addr_sequencer: programmable address sequence generator.
// Walks from a first address to a terminal address between runtime bounds
// with a runtime step, up or down, single pass or continuous wrap.
// Configuration is latched on start so upstream logic may change the inputs
// freely while a sequence runs.
module addr_sequencer #(
    parameter int ADDR_W = 16,
    parameter int STEP_W = 4,
    parameter int PASS_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              CNT_EN,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] limit,
    input  logic [STEP_W-1:0] step,
    input  logic              down,
    input  logic              wrap,
    output logic [ADDR_W-1:0] address,
    output logic              busy,
    output logic              last,
    output logic              done,
    output logic              cfg_err,
    output logic [PASS_W-1:0] passes
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_W-1:0] cfg_base;
    logic [ADDR_W-1:0] cfg_limit;
    logic [STEP_W-1:0] cfg_step;
    logic              cfg_down;
    logic              cfg_wrap;

    // A zero step would stall the sequence forever, so it is promoted to one
    logic [STEP_W-1:0] step_eff;
    assign step_eff = (step == '0) ? STEP_W'(1) : step;

    logic cfg_ok;
    assign cfg_ok = (base <= limit);

    // First address of a pass, from the inputs (at start) and from the latched config (on wrap)
    logic [ADDR_W-1:0] first_in;
    logic [ADDR_W-1:0] first_cfg;
    assign first_in  = down ? limit : base;
    assign first_cfg = cfg_down ? cfg_limit : cfg_base;

    // Distance to the bound in one extra bit so the subtraction can never wrap
    logic [ADDR_W:0] room;
    logic [ADDR_W:0] step_wide;
    assign room      = cfg_down ? ({1'b0, address} - {1'b0, cfg_base})
                                : ({1'b0, cfg_limit} - {1'b0, address});
    assign step_wide = (ADDR_W + 1)'(cfg_step);

    logic [ADDR_W-1:0] addr_next;
    assign addr_next = cfg_down ? (address - ADDR_W'(cfg_step))
                                : (address + ADDR_W'(cfg_step));

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: abort beats advance, DONE always falls back to IDLE
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start && cfg_ok) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (CNT_EN && last && !cfg_wrap) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Status outputs decoded from the registered state and address
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
        last = (state == RUN) && (room < step_wide);
    end

    // Configuration latch, address walk and saturating pass counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cfg_base  <= '0;
            cfg_limit <= '0;
            cfg_step  <= '0;
            cfg_down  <= 1'b0;
            cfg_wrap  <= 1'b0;
            address   <= '0;
            passes    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && cfg_ok) begin
                        cfg_base  <= base;
                        cfg_limit <= limit;
                        cfg_step  <= step_eff;
                        cfg_down  <= down;
                        cfg_wrap  <= wrap;
                        address   <= first_in;
                        passes    <= '0;
                    end
                end
                RUN: begin
                    if (!abort && CNT_EN) begin
                        if (!last) begin
                            address <= addr_next;
                        end else if (cfg_wrap) begin
                            address <= first_cfg;
                            if (passes != {PASS_W{1'b1}}) begin
                                passes <= passes + PASS_W'(1);
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Configuration error pulse: one cycle after a start with inverted bounds
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= (state == IDLE) && start && !cfg_ok;
        end
    end

endmodule

// File: tb/tb_addr_sequencer.sv
// tb_addr_sequencer: self-checking bench for addr_sequencer.
// Expected behaviour comes from a model that precomputes the whole address
// list of a pass when start is accepted and then just walks an index over it.
module tb_addr_sequencer;

    logic        clock;
    logic        reset;
    logic        start;
    logic        CNT_EN;
    logic        abort;
    logic [15:0] base;
    logic [15:0] limit;
    logic [3:0]  step;
    logic        down;
    logic        wrap;
    logic [15:0] address;
    logic        busy;
    logic        last;
    logic        done;
    logic        cfg_err;
    logic [7:0]  passes;

    int checks = 0;
    int errors = 0;

    addr_sequencer #(.ADDR_W(16), .STEP_W(4), .PASS_W(8)) dut (
        .clock(clock), .reset(reset), .start(start), .CNT_EN(CNT_EN),
        .abort(abort), .base(base), .limit(limit), .step(step),
        .down(down), .wrap(wrap), .address(address), .busy(busy),
        .last(last), .done(done), .cfg_err(cfg_err), .passes(passes)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: 0 idle, 1 running, 2 finished
    int          m_phase;
    int          seq[$];
    int          m_idx;
    logic [15:0] m_addr;
    int          m_passes;
    logic        m_cfg_err;
    logic        m_wrap;

    function automatic void model_reset();
        m_phase   = 0;
        m_addr    = 16'h0;
        m_passes  = 0;
        m_cfg_err = 1'b0;
        m_wrap    = 1'b0;
        m_idx     = 0;
        seq.delete();
    endfunction

    // Every address a pass visits, from first to terminal
    function automatic void build_seq();
        int s;
        int b;
        int l;
        seq.delete();
        s = (step == 4'd0) ? 1 : int'(step);
        b = int'(base);
        l = int'(limit);
        if (!down) begin
            for (int a = b; a <= l; a += s) seq.push_back(a);
        end else begin
            for (int a = l; a >= b; a -= s) seq.push_back(a);
        end
    endfunction

    function automatic void model_step();
        m_cfg_err = 1'b0;
        case (m_phase)
            0: begin
                if (start) begin
                    if (base > limit) begin
                        m_cfg_err = 1'b1;
                    end else begin
                        build_seq();
                        m_idx    = 0;
                        m_addr   = 16'(seq[0]);
                        m_passes = 0;
                        m_wrap   = wrap;
                        m_phase  = 1;
                    end
                end
            end
            1: begin
                if (abort) begin
                    m_phase = 0;
                end else if (CNT_EN) begin
                    if (m_idx < seq.size() - 1) begin
                        m_idx++;
                        m_addr = 16'(seq[m_idx]);
                    end else if (m_wrap) begin
                        m_idx  = 0;
                        m_addr = 16'(seq[0]);
                        if (m_passes < 255) m_passes++;
                    end else begin
                        m_phase = 2;
                    end
                end
            end
            default: m_phase = 0;
        endcase
    endfunction

    function automatic logic [27:0] expv();
        logic l;
        l = (m_phase == 1) && (m_idx == seq.size() - 1);
        return {m_addr, m_phase == 1, l, m_phase == 2, m_cfg_err, 8'(m_passes)};
    endfunction

    function automatic logic [27:0] obsv();
        return {address, busy, last, done, cfg_err, passes};
    endfunction

    // Drive one cycle of control inputs, advance the model, sample #1 after the edge
    task automatic tick(input logic st, input logic en, input logic ab);
        start  = st;
        CNT_EN = en;
        abort  = ab;
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_cfg(input logic [15:0] b, input logic [15:0] l,
                           input logic [3:0] s, input logic d, input logic w);
        base  = b;
        limit = l;
        step  = s;
        down  = d;
        wrap  = w;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        #23;
        checks++;
        if (obsv() !== 28'h0) begin
            errors++;
            $display("[TB] FAIL reset_state: got %h want %h", obsv(), 28'h0);
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        tick(1'b0, 1'b1, 1'b0);
        checks++;
        if (obsv() !== expv()) begin
            errors++;
            $display("[TB] FAIL reset_idle: got %h want %h", obsv(), expv());
        end
    endtask

    task automatic test_up_single();
        set_cfg(16'd4, 16'd7, 4'd1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        checks++;
        if (address !== 16'd4 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL up_first: got addr %0d busy %b want 4 1", address, busy);
        end
        for (int i = 0; i < 7; i++) begin
            tick(1'b0, 1'b1, 1'b0);
            checks++;
            if (obsv() !== expv()) begin
                errors++;
                $display("[TB] FAIL up_single cyc %0d: got %h want %h", i, obsv(), expv());
            end
        end
        checks++;
        if (address !== 16'd7 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL up_hold: got addr %0d busy %b want 7 0", address, busy);
        end
    endtask

    task automatic test_up_wrap();
        set_cfg(16'd0, 16'd10, 4'd3, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b1, 1'b0);
            checks++;
            if (obsv() !== expv() || done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL up_wrap cyc %0d: got %h want %h", i, obsv(), expv());
            end
        end
        tick(1'b0, 1'b0, 1'b1);
        checks++;
        if (obsv() !== expv()) begin
            errors++;
            $display("[TB] FAIL wrap_abort: got %h want %h", obsv(), expv());
        end
    endtask

    task automatic test_down();
        for (int k = 0; k < 2; k++) begin
            set_cfg(16'd2, 16'd5, (k == 0) ? 4'd2 : 4'd0, 1'b1, 1'b0);
            tick(1'b1, 1'b0, 1'b0);
            for (int i = 0; i < 6; i++) begin
                tick(1'b0, 1'b1, 1'b0);
                checks++;
                if (obsv() !== expv()) begin
                    errors++;
                    $display("[TB] FAIL down step%0d cyc %0d: got %h want %h", 2 - 2 * k, i, obsv(), expv());
                end
            end
        end
    endtask

    task automatic test_gaps_abort();
        int n;
        set_cfg(16'd0, 16'd20, 4'd2, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        n = 0;
        while (m_addr != 16'd6 && n < 200) begin
            set_cfg(16'($urandom), 16'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
            tick(1'($urandom), 1'($urandom), 1'b0);
            checks++;
            if (obsv() !== expv()) begin
                errors++;
                $display("[TB] FAIL gaps cyc %0d: got %h want %h", n, obsv(), expv());
            end
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("[TB] FAIL gaps_timeout: got addr %0d want 6", m_addr);
        end
        tick(1'b1, 1'b1, 1'b1);
        checks++;
        if (address !== 16'd6 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort: got addr %0d busy %b done %b want 6 0 0", address, busy, done);
        end
        tick(1'b0, 1'b1, 1'b0);
        checks++;
        if (obsv() !== expv()) begin
            errors++;
            $display("[TB] FAIL abort_idle: got %h want %h", obsv(), expv());
        end
    endtask

    task automatic test_boundaries();
        set_cfg(16'hFFF0, 16'hFFFF, 4'd8, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b1, 1'b0);
            checks++;
            if (obsv() !== expv()) begin
                errors++;
                $display("[TB] FAIL top_edge cyc %0d: got %h want %h", i, obsv(), expv());
            end
        end
        set_cfg(16'h0010, 16'h000F, 4'd1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        checks++;
        if (cfg_err !== 1'b1 || busy !== 1'b0 || obsv() !== expv()) begin
            errors++;
            $display("[TB] FAIL cfg_err_set: got %h want %h", obsv(), expv());
        end
        tick(1'b0, 1'b0, 1'b0);
        checks++;
        if (cfg_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL cfg_err_pulse: got %b want 0", cfg_err);
        end
        set_cfg(16'h0055, 16'h0055, 4'd3, 1'b1, 1'b1);
        tick(1'b1, 1'b0, 1'b0);
        checks++;
        if (last !== 1'b1 || address !== 16'h0055) begin
            errors++;
            $display("[TB] FAIL single_addr: got last %b addr %h want 1 0055", last, address);
        end
        for (int i = 0; i < 260; i++) tick(1'b0, 1'b1, 1'b0);
        checks++;
        if (passes !== 8'hFF || obsv() !== expv()) begin
            errors++;
            $display("[TB] FAIL pass_sat: got %h want %h", obsv(), expv());
        end
        tick(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_async_reset();
        set_cfg(16'd100, 16'd200, 4'd5, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obsv() !== 28'h0) begin
            errors++;
            $display("[TB] FAIL async_reset: got %h want %h", obsv(), 28'h0);
        end
        #3;
        reset = 1'b1;
        @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1, 1'b0);
            checks++;
            if (obsv() !== expv()) begin
                errors++;
                $display("[TB] FAIL post_reset cyc %0d: got %h want %h", i, obsv(), expv());
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] b;
        logic [15:0] l;
        int          span;
        for (int i = 0; i < 600; i++) begin
            b    = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFC0, 16'hFFFF))
                                               : 16'($urandom_range(0, 16'hFFFF));
            span = $urandom_range(0, 40);
            if ($urandom_range(0, 7) == 0) l = b - 16'(span + 1);
            else l = (int'(b) + span > 65535) ? 16'hFFFF : b + 16'(span);
            if (b < 16'd41 && l > b + 16'd40) l = b;
            set_cfg(b, l, 4'($urandom), 1'($urandom), 1'($urandom));
            tick($urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
            checks++;
            if (obsv() !== expv()) begin
                errors++;
                $display("[TB] FAIL random cyc %0d: got %h want %h", i, obsv(), expv());
            end
        end
    endtask

    initial begin
        start  = 1'b0;
        CNT_EN = 1'b0;
        abort  = 1'b0;
        set_cfg(16'h0, 16'h0, 4'd0, 1'b0, 1'b0);
        test_reset();
        test_up_single();
        test_up_wrap();
        test_down();
        test_gaps_abort();
        test_boundaries();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
